// File: rtl/sbus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
// The owner encoding doubles as the arbiter state encoding.
package sbus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  // Instruction fetches always read whole words; callers slice to their byte-enable width.
  localparam logic [63:0] ARB_BE_ALL = '1;

  function automatic int arb_cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sbus_arbiter.sv
// Two-master (instruction fetch / data) arbiter for one registered memory port,
// with a fetch starvation guard and a watchdog against slaves that never ack.
module sbus_arbiter
  import sbus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  output logic                i_err,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_err,

  output logic                s_req,
  output logic                s_we,
  output logic [DATA_W/8-1:0] s_be,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ack,
  input  logic                s_err,

  output logic [1:0]          owner
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = arb_cnt_width(MAX_WAIT);
  localparam int WW   = arb_cnt_width(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT);
  localparam bit            WD_EN      = (TIMEOUT > 0);

  arb_owner_e          state_q, state_d;
  logic                s_req_q, s_req_d;
  logic                s_we_q, s_we_d;
  logic [BE_W-1:0]     s_be_q, s_be_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
  logic [WW-1:0]       wd_cnt_q, wd_cnt_d;

  logic busy;
  logic timeout;
  logic done;
  logic fetch_wins;

  assign busy    = (state_q != OWN_NONE);
  assign timeout = WD_EN && busy && !s_ack && (wd_cnt_q == WD_MAX);
  assign done    = busy && (s_ack || timeout);

  // Data wins contention unless the fetch side has already lost MAX_WAIT times in a row.
  assign fetch_wins = i_req && (!d_req || (starve_cnt_q == STARVE_MAX));

  always_comb begin
    state_d      = state_q;
    s_req_d      = s_req_q;
    s_we_d       = s_we_q;
    s_be_d       = s_be_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = wd_cnt_q;

    case (state_q)
      OWN_NONE: begin
        if (fetch_wins) begin
          state_d      = OWN_I;
          s_req_d      = 1'b1;
          s_we_d       = 1'b0;
          s_be_d       = ARB_BE_ALL[BE_W-1:0];
          s_addr_d     = i_addr;
          s_wdata_d    = '0;
          starve_cnt_d = '0;
          wd_cnt_d     = '0;
        end else if (d_req) begin
          state_d   = OWN_D;
          s_req_d   = 1'b1;
          s_we_d    = d_we;
          s_be_d    = d_be;
          s_addr_d  = d_addr;
          s_wdata_d = d_wdata;
          wd_cnt_d  = '0;
          if (i_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end

      OWN_I, OWN_D: begin
        if (done) begin
          state_d = OWN_NONE;
          s_req_d = 1'b0;
        end else if (WD_EN) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = OWN_NONE;
        s_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= OWN_NONE;
      s_req_q      <= 1'b0;
      s_we_q       <= 1'b0;
      s_be_q       <= '0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      starve_cnt_q <= '0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      s_req_q      <= s_req_d;
      s_we_q       <= s_we_d;
      s_be_q       <= s_be_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  // Completion is returned combinationally; a watchdog expiry reports as an error.
  always_comb begin
    i_ack   = (state_q == OWN_I) && done;
    d_ack   = (state_q == OWN_D) && done;
    i_err   = i_ack && (s_ack ? s_err : 1'b1);
    d_err   = d_ack && (s_ack ? s_err : 1'b1);
    i_rdata = s_rdata;
    d_rdata = s_rdata;
  end

  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign s_be    = s_be_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign owner   = state_q;

endmodule

// File: tb/tb_sbus_arbiter.sv
// Directed bench for sbus_arbiter: priority/starvation order, fetch and store
// transfers, watchdog expiry with a stray late ack, and reset mid-transfer.
module tb_sbus_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        s_req;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ack;
  logic        s_err;
  logic [1:0]  owner;

  int vectorCount;
  int miscompareCount;

  sbus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(3), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .s_err(s_err),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe, input logic [3:0] dbe,
                               input logic [31:0] daddr, input logic [31:0] dwdata);
    i_req   = ireq;
    i_addr  = iaddr;
    d_req   = dreq;
    d_we    = dwe;
    d_be    = dbe;
    d_addr  = daddr;
    d_wdata = dwdata;
  endtask

  // Returns 1 time unit after the edge at which s_req first shows high.
  task automatic waitGrant();
    int n;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      if (s_req) n = 100;
      else n++;
    end
    if (n != 100) checkOutput("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic ackTransfer(input int delay, input logic [31:0] rdata, input logic err,
                             input logic expectI);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    s_ack   = 1'b1;
    s_rdata = rdata;
    s_err   = err;
    #2;
    checkOutput("i_ack", 64'(i_ack), 64'(expectI));
    checkOutput("d_ack", 64'(d_ack), 64'(!expectI));
    if (expectI) begin
      checkOutput("i_rdata", 64'(i_rdata), 64'(rdata));
      checkOutput("i_err", 64'(i_err), 64'(err));
    end else begin
      checkOutput("d_rdata", 64'(d_rdata), 64'(rdata));
      checkOutput("d_err", 64'(d_err), 64'(err));
    end
    @(posedge clk); #1;
    s_ack = 1'b0;
    s_err = 1'b0;
    checkOutput("idle_s_req", 64'(s_req), 64'd0);
    checkOutput("idle_owner", 64'(owner), 64'd0);
    checkOutput("idle_acks", 64'({i_ack, d_ack}), 64'd0);
  endtask

  initial begin
    logic [1:0] grantOrder [8];
    grantOrder = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
    vectorCount     = 0;
    miscompareCount = 0;
    rst     = 1'b0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rdata = '0;
    applyStimulus(1'b1, 32'hBFC0_0000, 1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_req", 64'(s_req), 64'd0);
    checkOutput("rst_owner", 64'(owner), 64'd0);
    checkOutput("rst_acks", 64'({i_ack, d_ack, i_err, d_err}), 64'd0);
    #2 rst = 1'b1;

    // Both masters hold requests: three data wins, then the forced fetch, twice over.
    for (int g = 0; g < 8; g++) begin
      waitGrant();
      checkOutput($sformatf("grant_%0d_owner", g), 64'(owner), 64'(grantOrder[g]));
      if (g == 0) checkOutput("starve_after_first", 64'(dut.starve_cnt_q), 64'd1);
      if (g == 2) checkOutput("starve_saturated", 64'(dut.starve_cnt_q), 64'd3);
      if (g == 3) checkOutput("starve_cleared", 64'(dut.starve_cnt_q), 64'd0);
      ackTransfer(0, 32'h1000 + 32'(g), 1'b0, grantOrder[g] == 2'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    applyStimulus(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitGrant();
    checkOutput("fetch_owner", 64'(owner), 64'd1);
    checkOutput("fetch_addr", 64'(s_addr), 64'hBFC0_0000);
    checkOutput("fetch_we", 64'(s_we), 64'd0);
    checkOutput("fetch_be", 64'(s_be), 64'hF);
    ackTransfer(3, 32'h3C08_0001, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF);
    waitGrant();
    checkOutput("store_owner", 64'(owner), 64'd2);
    checkOutput("store_we", 64'(s_we), 64'd1);
    checkOutput("store_be", 64'(s_be), 64'h3);
    checkOutput("store_addr", 64'(s_addr), 64'h8000_1000);
    checkOutput("store_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    ackTransfer(1, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Slave never answers: watchdog fires when wd_cnt hits 8.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8000_2000, 32'h0);
    waitGrant();
    for (int n = 1; n < 8; n++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("wd_wait_%0d", n), 64'(d_ack), 64'd0);
    end
    @(posedge clk); #1;
    checkOutput("wd_d_ack", 64'(d_ack), 64'd1);
    checkOutput("wd_d_err", 64'(d_err), 64'd1);
    checkOutput("wd_i_ack", 64'(i_ack), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("wd_idle_s_req", 64'(s_req), 64'd0);
    checkOutput("wd_idle_owner", 64'(owner), 64'd0);
    s_ack = 1'b1;
    #1;
    checkOutput("stray_ack", 64'({i_ack, d_ack}), 64'd0);
    @(posedge clk); #1;
    s_ack = 1'b0;
    checkOutput("stray_s_req", 64'(s_req), 64'd0);

    // Reset lands in the middle of a fetch; the still-pending request is regranted.
    applyStimulus(1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitGrant();
    checkOutput("mid_owner", 64'(owner), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_s_req", 64'(s_req), 64'd0);
    checkOutput("mid_rst_owner", 64'(owner), 64'd0);
    checkOutput("mid_rst_i_ack", 64'(i_ack), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    waitGrant();
    checkOutput("regrant_owner", 64'(owner), 64'd1);
    checkOutput("regrant_addr", 64'(s_addr), 64'hBFC0_0010);
    ackTransfer(0, 32'h1234_5678, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
